// File: rtl/beacon_if.sv
// Signal bundle between the beacon sequencer and its environment
// (decision counter, motor driver, mission control, status).
interface beacon_if;
    logic       enable;
    logic [2:0] final_answer;
    logic       final_done;
    logic       motor_ready;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic [2:0] state_out;
    logic       busy;
    logic [3:0] search_count;

    modport master (
        input  enable, final_answer, final_done, motor_ready,
        output cmd_valid, cmd_code, state_out, busy, search_count
    );

    modport slave (
        output enable, final_answer, final_done, motor_ready,
        input  cmd_valid, cmd_code, state_out, busy, search_count
    );
endinterface

// File: rtl/beacon_sequencer.sv
// Mission sequencer: turns confirmed beacon decisions into motor commands,
// times each leg, and issues SEARCH commands when no decision arrives.
module beacon_sequencer #(
    parameter int unsigned CMD_CYCLES     = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 200_000_000
) (
    input logic     clock,
    input logic     resetn,
    beacon_if.master bus
);
    localparam int unsigned RUN_W = (CMD_CYCLES > 1) ? $clog2(CMD_CYCLES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(CMD_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_ISSUE  = 3'd2,
        S_RUN    = 3'd3,
        S_HALT   = 3'd4,
        S_SEARCH = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       code_q, code_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [3:0]       search_q, search_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [2:0]       cmd_code_q, cmd_code_d;
    logic             busy_q, busy_d;
    logic             dec_valid, dec_stop;

    assign dec_valid = bus.final_done && (bus.final_answer != 3'd0) && (bus.final_answer <= 3'd4);
    assign dec_stop  = bus.final_done && (bus.final_answer == 3'd4);

    // Counters only advance in their own state and fall back to zero elsewhere,
    // so each state is always entered with a fresh count.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        run_d    = '0;
        to_d     = '0;
        search_d = search_q;
        unique case (state_q)
            S_IDLE: begin
                search_d = 4'd0;
                if (bus.enable) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dec_valid) begin
                    code_d  = bus.final_answer;
                    state_d = S_ISSUE;
                end else if (to_q == TO_LAST) begin
                    state_d = S_SEARCH;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_ISSUE: begin
                if (bus.motor_ready) state_d = (code_q == 3'd4) ? S_HALT : S_RUN;
            end
            S_RUN: begin
                if (dec_stop) begin
                    code_d  = 3'd4;
                    state_d = S_ISSUE;
                end else if (run_q == RUN_LAST) begin
                    state_d = S_WAIT;
                end else begin
                    run_d = run_q + 1'b1;
                end
            end
            S_HALT: ;
            S_SEARCH: begin
                if (bus.motor_ready) begin
                    if (search_q != 4'd15) search_d = search_q + 4'd1;
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Dropping enable overrides everything, including a pending transfer.
        if (!bus.enable) begin
            state_d  = S_IDLE;
            search_d = 4'd0;
        end
    end

    // Outputs are decoded from the next state and registered.
    always_comb begin
        cmd_valid_d = (state_d == S_ISSUE) || (state_d == S_SEARCH);
        busy_d      = (state_d == S_ISSUE) || (state_d == S_RUN) || (state_d == S_SEARCH);
        unique case (state_d)
            S_ISSUE:  cmd_code_d = code_d;
            S_SEARCH: cmd_code_d = 3'd5;
            S_HALT:   cmd_code_d = 3'd4;
            default:  cmd_code_d = 3'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            code_q      <= 3'd0;
            run_q       <= '0;
            to_q        <= '0;
            search_q    <= 4'd0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= 3'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            run_q       <= run_d;
            to_q        <= to_d;
            search_q    <= search_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.cmd_valid    = cmd_valid_q;
    assign bus.cmd_code     = cmd_code_q;
    assign bus.state_out    = state_q;
    assign bus.busy         = busy_q;
    assign bus.search_count = search_q;
endmodule

// File: doc/beacon_sequencer.md
BEACON_SEQUENCER -- requirements
Module: beacon_sequencer

Interface
REQ-001 Parameter: CMD_CYCLES, default 50_000_000; length of the RUN state in clock cycles (min 1).
REQ-002 Parameter: TIMEOUT_CYCLES, default 200_000_000; WAIT_DEC cycles without a valid decision before a search is issued (min 1).
REQ-003 Port: clock  input  1  single clock; all logic on the rising edge.
REQ-004 Port: resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-005 Port: enable  input  1  mission enable; low forces IDLE.
REQ-006 Port: final_answer  input  3  confirmed beacon code from the decision counter (1=R_B, 2=R_G, 3=B_G, 4=STOP).
REQ-007 Port: final_done  input  1  final_answer is valid this cycle.
REQ-008 Port: motor_ready  input  1  motor driver accepts the command this cycle.
REQ-009 Port: cmd_valid  output  1  command offered to the motor driver.
REQ-010 Port: cmd_code  output  3  command: 0=none, 1-3=leg, 4=STOP, 5=SEARCH.
REQ-011 Port: state_out  output  3  current state: IDLE=0, WAIT_DEC=1, ISSUE=2, RUN=3, HALT=4, SEARCH=5.
REQ-012 Port: busy  output  1  high in ISSUE, RUN and SEARCH.
REQ-013 Port: search_count  output  4  searches issued since leaving IDLE; saturates at 15.

Function
REQ-014 All outputs SHALL be registered; state_out, cmd_valid, cmd_code and busy SHALL reflect the current state with no combinational path from inputs.
REQ-015 IDLE: go to WAIT_DEC on the first edge with enable=1; clear search_count, the run counter and the timeout counter.
REQ-016 WAIT_DEC: on final_done=1 with final_answer in 1..4, latch the code and go to ISSUE on the next edge (1-cycle latency); codes 0, 5, 6 and 7 are ignored.
REQ-017 WAIT_DEC: the timeout counter increments every cycle; when it reaches TIMEOUT_CYCLES-1 without a valid decision, go to SEARCH.
REQ-018 WAIT_DEC: if a valid decision and timeout expiry occur in the same cycle, the decision wins.
REQ-019 ISSUE: cmd_valid=1 and cmd_code=latched code; cmd_code SHALL hold stable until transfer.
REQ-020 Transfer occurs on the edge where cmd_valid=1 and motor_ready=1. After transfer, go to HALT if the code is 4, otherwise to RUN. cmd_valid is 0 in the following cycle.
REQ-021 RUN: cmd_valid=0; stay exactly CMD_CYCLES cycles, then go to WAIT_DEC with the timeout counter cleared.
REQ-022 RUN: final_done=1 with final_answer=4 preempts the run; latch 4 and go to ISSUE next edge. Other codes are ignored. A STOP arriving on the run-expiry cycle wins over expiry.
REQ-023 SEARCH: cmd_valid=1, cmd_code=5. On transfer, increment search_count (saturating at 15), clear the timeout counter and return to WAIT_DEC. final_done is ignored in SEARCH.
REQ-024 HALT: terminal; cmd_valid=0, cmd_code=4; leave only to IDLE via enable=0.
REQ-025 enable=0 in any state SHALL go to IDLE on the next edge, dropping cmd_valid even mid-handshake; no transfer occurs on that edge.
REQ-026 Counters SHALL be wide enough for their parameters (ceil log2) and SHALL never wrap.

Reset
REQ-027 resetn=0 at an edge SHALL set: state IDLE, cmd_valid=0, cmd_code=0, state_out=0, busy=0, search_count=0, and both counters and the latched code to 0. Reset has priority over all inputs.
REQ-028 Reset asserted mid-ISSUE, RUN or SEARCH SHALL abort without a transfer; after release, operation restarts from IDLE.

Verification (CMD_CYCLES=8, TIMEOUT_CYCLES=20)
REQ-029 enable=1, then final_done pulse with code 2 -> ISSUE next cycle, cmd_code=2. motor_ready held 0 for 3 cycles then 1 -> cmd_valid high 4 cycles, RUN for exactly 8 cycles, then WAIT_DEC.
REQ-030 No final_done for 20 cycles in WAIT_DEC -> SEARCH with cmd_code=5. After ready, search_count=1 and back in WAIT_DEC. Repeat 16 times -> search_count stays 15.
REQ-031 Code 4 during RUN cycle 3 -> ISSUE with code 4, then HALT after transfer. Later decisions are ignored. enable=0 -> IDLE next cycle.
REQ-032 Code 4 coincident with the last RUN cycle -> ISSUE with code 4, not WAIT_DEC. Valid decision on the timeout-expiry cycle -> ISSUE, not SEARCH.
REQ-033 final_answer=0 and 6 with final_done=1 in WAIT_DEC -> remain in WAIT_DEC, timeout continues counting.
REQ-034 resetn=0 mid-ISSUE with motor_ready=1 -> no transfer. All outputs are 0 next cycle and state_out=0.
